rf_param: RTL and testbench

Parametrised general-purpose register file for the single-cycle datapath. It has two asynchronous read ports and one synchronous write port with byte strobes. A zero-register option and an optional write-to-read bypass are selectable by parameter. Contents are cleared by a sequential clear engine, which runs after reset or on request, and the block reports a busy flag while the engine runs.

---
 rtl/rf_param_if.sv | 27 ++
 rtl/rf_param.sv | 111 +++++++++++
 tb/tb_rf_param.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_param_if.sv
// Register-file access bus: one write port with byte strobes, two read ports,
// plus the clear request and busy status of the clear engine.
interface rf_param_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic                  i_clear;
  logic                  i_we;
  logic [ADDR_W-1:0]     i_waddr;
  logic [DATA_W-1:0]     i_wdata;
  logic [DATA_W/8-1:0]   i_wstrb;
  logic [ADDR_W-1:0]     i_raddr1;
  logic [ADDR_W-1:0]     i_raddr2;
  logic [DATA_W-1:0]     o_rdata1;
  logic [DATA_W-1:0]     o_rdata2;
  logic                  o_busy;

  modport master (
    output i_clear, i_we, i_waddr, i_wdata, i_wstrb, i_raddr1, i_raddr2,
    input  o_rdata1, o_rdata2, o_busy
  );

  modport slave (
    input  i_clear, i_we, i_waddr, i_wdata, i_wstrb, i_raddr1, i_raddr2,
    output o_rdata1, o_rdata2, o_busy
  );
endinterface

// File: rtl/rf_param.sv
// Parametrised register file: two combinational read ports, one byte-strobed
// write port, optional hard-wired zero entry and write-to-read bypass.
module rf_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  rf_param_if.slave bus
);
  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned NB    = DATA_W/8;

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   cnt_nxt;
  logic                busy;
  logic                wr_en;
  logic                clr_en;
  logic [DATA_W-1:0]   regs [DEPTH];
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  logic                byp1;
  logic                byp2;

  // State register; reset restarts the clear engine from entry 0
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: walk every entry once, then return to IDLE
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.i_clear) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      end
      S_CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == ADDR_W'(DEPTH-1)) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode: writes only land in IDLE and never to a hard-wired zero entry
  always_comb begin
    busy   = 1'b0;
    wr_en  = 1'b0;
    clr_en = 1'b0;
    case (state)
      S_IDLE:  wr_en = bus.i_we && !i_rst && !(ZERO_REG && (bus.i_waddr == '0));
      S_CLEAR: begin
        busy   = 1'b1;
        clr_en = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Stored word with the strobed lanes replaced: the post-edge value of the entry
  always_comb begin
    wr_merged = regs[bus.i_waddr];
    for (int k = 0; k < NB; k++) begin
      if (bus.i_wstrb[k]) wr_merged[8*k +: 8] = bus.i_wdata[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (clr_en) regs[cnt] <= '0;
    else if (wr_en) regs[bus.i_waddr] <= wr_merged;
  end

  assign byp1 = BYPASS && bus.i_we && (bus.i_waddr == bus.i_raddr1);
  assign byp2 = BYPASS && bus.i_we && (bus.i_waddr == bus.i_raddr2);

  // Read ports: later assignments take priority (busy > zero entry > bypass > storage)
  always_comb begin
    rdata1 = regs[bus.i_raddr1];
    if (byp1) rdata1 = wr_merged;
    if (ZERO_REG && (bus.i_raddr1 == '0)) rdata1 = '0;
    if (busy) rdata1 = '0;
  end

  always_comb begin
    rdata2 = regs[bus.i_raddr2];
    if (byp2) rdata2 = wr_merged;
    if (ZERO_REG && (bus.i_raddr2 == '0)) rdata2 = '0;
    if (busy) rdata2 = '0;
  end

  assign bus.o_rdata1 = rdata1;
  assign bus.o_rdata2 = rdata2;
  assign bus.o_busy   = busy;
endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: directed scenarios then random traffic, checked against
// a behavioural model of two configurations (zero+bypass, and neither).
module tb_rf_param;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;

  logic              clk;
  logic              rst;
  logic              clear;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;

  int checks = 0;
  int errors = 0;

  // model: cfg 0 = ZERO_REG=1/BYPASS=1, cfg 1 = ZERO_REG=0/BYPASS=0
  logic [DATA_W-1:0] mem [2][DEPTH];
  int busy_left;

  rf_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifa ();
  rf_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ifb ();

  assign ifa.i_clear = clear;  assign ifb.i_clear = clear;
  assign ifa.i_we    = we;     assign ifb.i_we    = we;
  assign ifa.i_waddr = waddr;  assign ifb.i_waddr = waddr;
  assign ifa.i_wdata = wdata;  assign ifb.i_wdata = wdata;
  assign ifa.i_wstrb = wstrb;  assign ifb.i_wstrb = wstrb;
  assign ifa.i_raddr1 = ra1;   assign ifb.i_raddr1 = ra1;
  assign ifa.i_raddr2 = ra2;   assign ifb.i_raddr2 = ra2;

  rf_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(ifa)
  );
  rf_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] merged(input logic [DATA_W-1:0] old);
    logic [DATA_W-1:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (wstrb[k]) r[8*k +: 8] = wdata[8*k +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(input int cfg, input logic [ADDR_W-1:0] a);
    if (busy_left > 0) return '0;
    if (cfg == 0 && a == 0) return '0;
    if (cfg == 0 && we && waddr == a) return merged(mem[cfg][a]);
    return mem[cfg][a];
  endfunction

  // Clock-edge effect on the model: clearing zeroes everything at once, since
  // nothing is observable until busy drops
  task automatic model_step();
    if (rst) begin
      busy_left = DEPTH;
      for (int c = 0; c < 2; c++) for (int i = 0; i < DEPTH; i++) mem[c][i] = '0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (we) begin
        if (waddr != 0) mem[0][waddr] = merged(mem[0][waddr]);
        mem[1][waddr] = merged(mem[1][waddr]);
      end
      if (clear) begin
        busy_left = DEPTH;
        for (int c = 0; c < 2; c++) for (int i = 0; i < DEPTH; i++) mem[c][i] = '0;
      end
    end
  endtask

  task automatic model_check();
    logic [DATA_W-1:0] eb;
    eb = (busy_left > 0) ? 32'd1 : 32'd0;
    chk("busy_a", 32'(ifa.o_busy), eb);
    chk("busy_b", 32'(ifb.o_busy), eb);
    chk("rd1_a", ifa.o_rdata1, exp_rd(0, ra1));
    chk("rd2_a", ifa.o_rdata2, exp_rd(0, ra2));
    chk("rd1_b", ifb.o_rdata1, exp_rd(1, ra1));
    chk("rd2_b", ifb.o_rdata2, exp_rd(1, ra2));
  endtask

  task automatic step();
    #1;
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [3:0] s);
    we = 1'b1; waddr = a; wdata = d; wstrb = s;
    step();
    we = 1'b0;
  endtask

  task automatic count_busy(input string tag, input logic drive_wr);
    int n;
    n = 0;
    while (ifa.o_busy && n < 100) begin
      if (drive_wr) begin
        we = 1'b1; waddr = 5'd2; wdata = 32'h9; wstrb = 4'hF;
      end
      n++;
      step();
    end
    we = 1'b0;
    chk(tag, 32'(n), 32'd32);
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      ra1 = ADDR_W'(i);
      ra2 = ADDR_W'(DEPTH - 1 - i);
      #1;
      chk(tag, ifa.o_rdata1, 32'h0);
      chk(tag, ifb.o_rdata1, 32'h0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    ra1 = '0; ra2 = '0;
    busy_left = 0;
    @(posedge clk);
    model_step();
    #1;
    step();
    rst = 1'b0;

    count_busy("reset_busy_len", 1'b0);
    read_all_zero("reset_zero");

    // full then partial byte write
    ra1 = 5'd5; ra2 = 5'd5;
    wr(5'd5, 32'hDEADBEEF, 4'hF);
    wr(5'd5, 32'h000000AA, 4'h1);
    #1;
    chk("r5_byte_a", ifa.o_rdata1, 32'hDEADBEAA);
    chk("r5_byte_b", ifb.o_rdata2, 32'hDEADBEAA);
    wr(5'd5, 32'hFFFFFFFF, 4'h0);
    #1;
    chk("r5_nostrb", ifa.o_rdata1, 32'hDEADBEAA);

    // zero register
    wr(5'd0, 32'h12345678, 4'hF);
    ra1 = 5'd0; ra2 = 5'd0;
    #1;
    chk("r0_zero_a1", ifa.o_rdata1, 32'h0);
    chk("r0_zero_a2", ifa.o_rdata2, 32'h0);
    chk("r0_plain_b", ifb.o_rdata1, 32'h12345678);
    step();

    // bypass versus no bypass
    wr(5'd7, 32'h11111111, 4'hF);
    ra1 = 5'd7; ra2 = 5'd7;
    we = 1'b1; waddr = 5'd7; wdata = 32'hFFFF0000; wstrb = 4'hC;
    #1;
    chk("byp_a1", ifa.o_rdata1, 32'hFFFF1111);
    chk("byp_a2", ifa.o_rdata2, 32'hFFFF1111);
    chk("nobyp_b1", ifb.o_rdata1, 32'h11111111);
    step();
    we = 1'b0;
    #1;
    chk("nobyp_b_next", ifb.o_rdata1, 32'hFFFF1111);
    step();

    // clear request with concurrent write, writes dropped while busy
    wr(5'd1, 32'hA1, 4'hF);
    wr(5'd2, 32'hA2, 4'hF);
    wr(5'd3, 32'hA3, 4'hF);
    clear = 1'b1;
    wr(5'd4, 32'h5, 4'hF);
    clear = 1'b0;
    count_busy("clear_busy_len", 1'b1);
    read_all_zero("clear_zero");

    // reset in the middle of a clear
    wr(5'd9, 32'hCAFE, 4'hF);
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy("midclr_busy_len", 1'b0);
    read_all_zero("midclr_zero");

    // held clear: back-to-back clears with a single idle cycle between
    clear = 1'b1;
    for (int i = 0; i < 70; i++) step();
    clear = 1'b0;
    for (int i = 0; i < 34; i++) step();

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 299) == 0);
      clear = ($urandom_range(0, 149) == 0);
      we    = ($urandom_range(0, 3) != 0);
      waddr = ADDR_W'($urandom_range(0, 7));
      wdata = $urandom;
      wstrb = 4'($urandom_range(0, 15));
      ra1   = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      ra2   = ($urandom_range(0, 1) == 0) ? waddr : ADDR_W'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
